route_compute_buffer: RTL

- Input stage of the 3-port router (ports X, Y, LOCAL); sits directly upstream of the port-allocation / transport stage.
- Per input port: buffers incoming flits in a small FIFO and runs XY dimension-order routing on the head flit's destination.
- Drives the 2-bit direction codes router_algorithm_out_x/_y/_local plus head flit data.
- Downstream pops a flit once its transfer is granted.

---
 rtl/route_compute_buffer.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/route_compute_buffer.sv
// route_compute_buffer: input stage of the 3-port router (X, Y, LOCAL).
// Each input has a small FIFO. The direction code and payload of the head
// flit are registered and come from XY dimension-order routing.
// Optional build macro ROUTE_STARVE_CNT_EN adds per-port starvation flags.

module rcb_port #(
  parameter int DATA_W  = 16,
  parameter int COORD_W = 2,
  parameter int DEPTH   = 4,
  parameter int CUR_X   = 0,
  parameter int CUR_Y   = 0
`ifdef ROUTE_STARVE_CNT_EN
  , parameter int STARVE_LIMIT = 15
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              ready_o,
  input  logic              pop_i,
  output logic [1:0]        code_o,
  output logic [DATA_W-1:0] head_o
`ifdef ROUTE_STARVE_CNT_EN
  , output logic            starve_o
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [COORD_W-1:0] CX = COORD_W'(CUR_X);
  localparam logic [COORD_W-1:0] CY = COORD_W'(CUR_Y);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]     count_q, count_d, remain;
  logic [1:0]        code_q, code_d;
  logic [DATA_W-1:0] head_q, head_d;
  logic              push, pop_fire;

  function automatic logic [1:0] route(input logic [DATA_W-1:0] f);
    if (f[COORD_W-1:0] != CX)               return 2'b01;
    else if (f[2*COORD_W-1:COORD_W] != CY) return 2'b10;
    else                                   return 2'b11;
  endfunction

  // Next pointers, occupancy, and the head flit as it will look after this edge.
  // When the old contents are all consumed, the flit being written becomes the head.
  always_comb begin
    push     = valid_i && (count_q != FULL_CNT);
    pop_fire = pop_i && (count_q != '0);
    rd_ptr_d = rd_ptr_q + AW'(pop_fire);
    wr_ptr_d = wr_ptr_q + AW'(push);
    count_d  = count_q + CW'(push) - CW'(pop_fire);
    remain   = count_q - CW'(pop_fire);
    head_d   = head_q;
    code_d   = 2'b00;
    if (count_d != '0) begin
      if (remain == '0) head_d = data_i;
      else              head_d = mem_q[rd_ptr_d];
      code_d = route(head_d);
    end
  end

  // Storage array; contents need no reset since occupancy gates every read.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= data_i;
  end

  // Pointer, count and registered head state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      code_q   <= 2'b00;
      head_q   <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      code_q   <= code_d;
      head_q   <= head_d;
    end
  end

  assign ready_o = (count_q != FULL_CNT);
  assign code_o  = code_q;
  assign head_o  = head_q;

`ifdef ROUTE_STARVE_CNT_EN
  localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);
  logic [7:0] starve_cnt_q, starve_cnt_d;
  logic       starve_q;

  // Counts cycles the head sits unpopped; saturates so the flag cannot wrap off.
  always_comb begin
    starve_cnt_d = 8'd0;
    if ((count_q != '0) && !pop_fire)
      starve_cnt_d = (starve_cnt_q == 8'hFF) ? 8'hFF : starve_cnt_q + 8'd1;
  end

  // Starvation counter and registered flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt_q <= 8'd0;
      starve_q     <= 1'b0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      starve_q     <= (starve_cnt_d >= LIMIT);
    end
  end

  assign starve_o = starve_q;
`endif
endmodule

module route_compute_buffer #(
  parameter int DATA_W  = 16,
  parameter int COORD_W = 2,
  parameter int DEPTH   = 4,
  parameter int CUR_X   = 0,
  parameter int CUR_Y   = 0
`ifdef ROUTE_STARVE_CNT_EN
  , parameter int STARVE_LIMIT = 15
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid_x,
  input  logic              in_valid_y,
  input  logic              in_valid_local,
  input  logic [DATA_W-1:0] in_data_x,
  input  logic [DATA_W-1:0] in_data_y,
  input  logic [DATA_W-1:0] in_data_local,
  output logic              in_ready_x,
  output logic              in_ready_y,
  output logic              in_ready_local,
  input  logic              pop_x,
  input  logic              pop_y,
  input  logic              pop_local,
  output logic [1:0]        router_algorithm_out_x,
  output logic [1:0]        router_algorithm_out_y,
  output logic [1:0]        router_algorithm_out_local,
  output logic [DATA_W-1:0] head_data_x,
  output logic [DATA_W-1:0] head_data_y,
  output logic [DATA_W-1:0] head_data_local
`ifdef ROUTE_STARVE_CNT_EN
  , output logic            starve_x,
  output logic              starve_y,
  output logic              starve_local
`endif
);
`ifdef ROUTE_STARVE_CNT_EN
  `define RCB_PARAMS #(.DATA_W(DATA_W), .COORD_W(COORD_W), .DEPTH(DEPTH), .CUR_X(CUR_X), .CUR_Y(CUR_Y), .STARVE_LIMIT(STARVE_LIMIT))
`else
  `define RCB_PARAMS #(.DATA_W(DATA_W), .COORD_W(COORD_W), .DEPTH(DEPTH), .CUR_X(CUR_X), .CUR_Y(CUR_Y))
`endif

  rcb_port `RCB_PARAMS u_port_x (
    .clk(clk), .rst_n(rst_n), .valid_i(in_valid_x), .data_i(in_data_x),
    .ready_o(in_ready_x), .pop_i(pop_x), .code_o(router_algorithm_out_x),
    .head_o(head_data_x)
`ifdef ROUTE_STARVE_CNT_EN
    , .starve_o(starve_x)
`endif
  );

  rcb_port `RCB_PARAMS u_port_y (
    .clk(clk), .rst_n(rst_n), .valid_i(in_valid_y), .data_i(in_data_y),
    .ready_o(in_ready_y), .pop_i(pop_y), .code_o(router_algorithm_out_y),
    .head_o(head_data_y)
`ifdef ROUTE_STARVE_CNT_EN
    , .starve_o(starve_y)
`endif
  );

  rcb_port `RCB_PARAMS u_port_local (
    .clk(clk), .rst_n(rst_n), .valid_i(in_valid_local), .data_i(in_data_local),
    .ready_o(in_ready_local), .pop_i(pop_local), .code_o(router_algorithm_out_local),
    .head_o(head_data_local)
`ifdef ROUTE_STARVE_CNT_EN
    , .starve_o(starve_local)
`endif
  );

`undef RCB_PARAMS
endmodule
